// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int DW = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        FAULT
    } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Word-wide request/ready data-memory port.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = DW
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  MemReq;
    logic                  MemWe;
    logic [DATA_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWData;
    logic [BE_WIDTH-1:0]   MemBe;
    logic                  MemReady;
    logic [DATA_WIDTH-1:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemBe,
        input  MemReady, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemBe,
        output MemReady, MemRData
    );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a read word and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  ls_type,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b     = word[{addr, 3'b000} +: 8];
        h     = addr[1] ? word[31:16] : word[15:0];
        rdata = word;
        unique case (1'b1)
            ls_type == LS_B:  rdata = {{24{b[7]}}, b};
            ls_type == LS_H:  rdata = {{16{h[15]}}, h};
            ls_type == LS_BU: rdata = {24'b0, b};
            ls_type == LS_HU: rdata = {16'b0, h};
            default:          rdata = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: checks, issues and completes one load/store at a time.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  LsuValid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            LsType,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Stall,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Fault,
    lsu_if.master                 mem
);

    lsu_state_t            state;
    logic                  op, type_ok, misalign, illegal;
    logic [1:0]            lo;
    logic [BE_WIDTH-1:0]   be_n;
    logic [DATA_WIDTH-1:0] wd_n;

    logic                  mem_req, resp_valid, fault, we_q;
    logic [1:0]            lo_q;
    logic [2:0]            type_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] addr_q, wd_q, rdata_q, aligned;

    assign lo = ALUResult[1:0];
    assign op = LsuValid & (MemRead | MemWrite);

    always_comb begin
        type_ok = 1'b0;
        case (LsType)
            LS_B, LS_H, LS_W: type_ok = 1'b1;
            LS_BU, LS_HU:     type_ok = ~MemWrite;
            default:          type_ok = 1'b0;
        endcase
        if (MemRead & MemWrite) type_ok = 1'b0;
    end

    assign misalign = ((LsType[1:0] == 2'b01) & lo[0])
                    | ((LsType[1:0] == 2'b10) & (|lo));
    assign illegal  = ~type_ok | misalign;

    // Store lanes are replicated so the byte enables alone pick the target.
    always_comb begin
        be_n = '1;
        wd_n = WriteData;
        unique case (1'b1)
            LsType[1:0] == 2'b00: begin
                be_n = 4'b0001 << lo;
                wd_n = {4{WriteData[7:0]}};
            end
            LsType[1:0] == 2'b01: begin
                be_n = 4'b0011 << lo;
                wd_n = {2{WriteData[15:0]}};
            end
            default: begin
                be_n = '1;
                wd_n = WriteData;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            we_q       <= 1'b0;
            lo_q       <= '0;
            type_q     <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            rdata_q    <= '0;
        end else begin
            resp_valid <= 1'b0;
            fault      <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (op && illegal) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (op) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        we_q    <= MemWrite;
                        lo_q    <= lo;
                        type_q  <= LsType;
                        be_q    <= be_n;
                        addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        wd_q    <= wd_n;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (mem.MemReady) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        rdata_q    <= mem.MemRData;
                    end
                end
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    lsu_load_align u_align (
        .word    (rdata_q),
        .addr    (lo_q),
        .ls_type (type_q),
        .rdata   (aligned)
    );

    assign Stall        = op | (state == REQ);
    assign RespValid    = resp_valid;
    assign Fault        = fault;
    assign ReadData     = (resp_valid & ~we_q) ? aligned : '0;
    assign mem.MemReq   = mem_req;
    assign mem.MemWe    = we_q;
    assign mem.MemAddr  = addr_q;
    assign mem.MemWData = wd_q;
    assign mem.MemBe    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic vs a transaction model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        LsuValid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  LsType = 3'b0;
    logic [31:0] ALUResult = '0, WriteData = '0;
    logic        Stall, RespValid, Fault;
    logic [31:0] ReadData;

    always #5 clk = ~clk;

    lsu_if #(.DATA_WIDTH(32)) m ();

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .LsuValid  (LsuValid),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .LsType    (LsType),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Stall     (Stall),
        .RespValid (RespValid),
        .ReadData  (ReadData),
        .Fault     (Fault),
        .mem       (m)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // environment memory follows the DUT's writes; model memory follows the model's
    logic [31:0] env_mem [64] = '{default: '0};
    logic [31:0] mod_mem [64] = '{default: '0};

    assign m.MemRData = env_mem[m.MemAddr[7:2]];

    always @(posedge clk) begin
        if (m.MemReq && m.MemReady && m.MemWe)
            for (int i = 0; i < 4; i++)
                if (m.MemBe[i])
                    env_mem[m.MemAddr[7:2]][8*i +: 8] <= m.MemWData[8*i +: 8];
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(bit r, bit w, logic [2:0] t, logic [31:0] a);
        int sz;
        if (r && w) return 1'b0;
        if (w && t > 3'd2) return 1'b0;
        if (r && !(t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        sz = 1 << t[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] be_of(logic [2:0] t, logic [31:0] a);
        int sz = 1 << t[1:0];
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] rep(logic [2:0] t, logic [31:0] d);
        case (t[1:0])
            2'd0:    return (d & 32'hFF) * 32'h0101_0101;
            2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ext(logic [31:0] w, logic [2:0] t, logic [1:0] lo);
        logic [31:0] s = w >> (8 * lo);
        byte         sb = s[7:0];
        shortint     sh = s[15:0];
        case (t)
            3'd0:    return 32'(int'(sb));
            3'd1:    return 32'(int'(sh));
            3'd4:    return s & 32'hFF;
            3'd5:    return s & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // transaction model: at most one outstanding access, results from plain arithmetic
    bit          m_pend, m_resp, m_fault, m_we;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [3:0]  m_be;
    logic [2:0]  m_t;
    logic [1:0]  m_lo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  <= 1'b0;
            m_resp  <= 1'b0;
            m_fault <= 1'b0;
        end else begin
            m_resp  <= 1'b0;
            m_fault <= 1'b0;
            if (m_pend) begin
                if (m.MemReady) begin
                    m_pend <= 1'b0;
                    m_resp <= 1'b1;
                    m_rd   <= m_we ? 32'h0 : ext(mod_mem[m_addr[7:2]], m_t, m_lo);
                    if (m_we)
                        for (int i = 0; i < 4; i++)
                            if (m_be[i])
                                mod_mem[m_addr[7:2]][8*i +: 8] <= m_wd[8*i +: 8];
                end
            end else if (!m_fault && LsuValid && (MemRead || MemWrite)) begin
                if (legal(MemRead, MemWrite, LsType, ALUResult)) begin
                    m_pend <= 1'b1;
                    m_we   <= MemWrite;
                    m_addr <= ALUResult & ~32'h3;
                    m_lo   <= ALUResult[1:0];
                    m_t    <= LsType;
                    m_be   <= be_of(LsType, ALUResult);
                    m_wd   <= rep(LsType, WriteData);
                end else begin
                    m_fault <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("stall", 32'(Stall), 32'((LsuValid && (MemRead || MemWrite)) || m_pend));
            chk("memreq", 32'(m.MemReq), 32'(m_pend));
            if (m_pend) begin
                chk("memaddr", m.MemAddr, m_addr);
                chk("memwe", 32'(m.MemWe), 32'(m_we));
                chk("membe", 32'(m.MemBe), 32'(m_be));
                chk("memwdata", m.MemWData, m_wd);
            end
            chk("respvalid", 32'(RespValid), 32'(m_resp));
            if (m_resp) chk("readdata", ReadData, m_rd);
            chk("fault", 32'(Fault), 32'(m_fault));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, bit r, bit w, logic [2:0] t, logic [31:0] a, logic [31:0] d);
        LsuValid  = v;
        MemRead   = r;
        MemWrite  = w;
        LsType    = t;
        ALUResult = a;
        WriteData = d;
    endtask

    task automatic run_op(input bit r, input bit w, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d, input int waits,
                          output logic [31:0] rd, output int nreq, output int lat,
                          output bit flt, output logic [3:0] be, output logic [31:0] wdv);
        rd = '0; nreq = 0; lat = 0; flt = 1'b0; be = '0; wdv = '0;
        step();
        drive(1'b1, r, w, t, a, d);
        m.MemReady = 1'b0;
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        for (int c = 1; c < 40; c++) begin
            #1;
            if (Fault) begin flt = 1'b1; lat = c; break; end
            if (RespValid) begin rd = ReadData; lat = c; break; end
            if (m.MemReq) begin
                if (nreq == 0) begin be = m.MemBe; wdv = m.MemWData; end
                nreq++;
                m.MemReady = (nreq > waits);
            end
            step();
        end
        m.MemReady = 1'b0;
    endtask

    logic [31:0] rd, wdv;
    logic [3:0]  be;
    int          nreq, lat;
    bit          flt;
    logic [2:0]  legal_t [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        m.MemReady = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 32'(Stall), 32'h0);
        chk("rst_resp", 32'(RespValid), 32'h0);
        chk("rst_fault", 32'(Fault), 32'h0);
        chk("rst_req", 32'(m.MemReq), 32'h0);
        chk("rst_addr", m.MemAddr, 32'h0);
        chk("rst_be", 32'(m.MemBe), 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // SW with immediate ready
        step();
        drive(1'b1, 1'b0, 1'b1, LS_W, 32'h100, 32'hDEADBEEF);
        m.MemReady = 1'b1;
        #1 chk("sw_c0_stall", 32'(Stall), 32'h1);
        chk("sw_c0_req", 32'(m.MemReq), 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        #1 chk("sw_c1_req", 32'(m.MemReq), 32'h1);
        chk("sw_c1_addr", m.MemAddr, 32'h100);
        chk("sw_c1_be", 32'(m.MemBe), 32'hF);
        chk("sw_c1_wd", m.MemWData, 32'hDEADBEEF);
        chk("sw_c1_we", 32'(m.MemWe), 32'h1);
        chk("sw_c1_stall", 32'(Stall), 32'h1);
        step();
        #1 chk("sw_c2_resp", 32'(RespValid), 32'h1);
        chk("sw_c2_stall", 32'(Stall), 32'h0);
        m.MemReady = 1'b0;

        run_op(1'b0, 1'b1, LS_W, 32'h200, 32'h80FF_1234, 0, rd, nreq, lat, flt, be, wdv);
        run_op(1'b1, 1'b0, LS_B, 32'h203, '0, 3, rd, nreq, lat, flt, be, wdv);
        chk("lb_rd", rd, 32'hFFFF_FF80);
        chk("lb_nreq", 32'(nreq), 32'd4);
        chk("lb_lat", 32'(lat), 32'd5);
        chk("lb_be", 32'(be), 32'h8);
        run_op(1'b1, 1'b0, LS_BU, 32'h203, '0, 3, rd, nreq, lat, flt, be, wdv);
        chk("lbu_rd", rd, 32'h0000_0080);

        run_op(1'b0, 1'b1, LS_W, 32'h200, 32'h8001_7FFF, 0, rd, nreq, lat, flt, be, wdv);
        run_op(1'b1, 1'b0, LS_H, 32'h202, '0, 1, rd, nreq, lat, flt, be, wdv);
        chk("lh_rd", rd, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, LS_HU, 32'h202, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("lhu_rd", rd, 32'h0000_8001);
        run_op(1'b0, 1'b1, LS_H, 32'h202, 32'h1234_ABCD, 0, rd, nreq, lat, flt, be, wdv);
        chk("sh_wd", wdv, 32'hABCD_ABCD);
        chk("sh_be", 32'(be), 32'hC);
        chk("sh_rd", rd, 32'h0);
        run_op(1'b1, 1'b0, LS_W, 32'h200, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("lw_after_sh", rd, 32'hABCD_7FFF);

        run_op(1'b1, 1'b0, LS_W, 32'h101, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("lw_mis_flt", 32'(flt), 32'h1);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_nreq", 32'(nreq), 32'd0);
        run_op(1'b1, 1'b0, LS_H, 32'h105, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("lh_mis_flt", 32'(flt), 32'h1);
        run_op(1'b1, 1'b0, 3'b011, 32'h100, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("ld_t3_flt", 32'(flt), 32'h1);
        run_op(1'b1, 1'b1, LS_W, 32'h100, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("rw_flt", 32'(flt), 32'h1);

        // back-to-back: SB then LW presented during RESP
        run_op(1'b0, 1'b1, LS_W, 32'h20, 32'hCAFE_F00D, 0, rd, nreq, lat, flt, be, wdv);
        step();
        drive(1'b1, 1'b0, 1'b1, LS_B, 32'h10, 32'h0000_005A);
        m.MemReady = 1'b1;
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        #1 chk("b2b_c1_req", 32'(m.MemReq), 32'h1);
        chk("b2b_c1_wd", m.MemWData, 32'h5A5A_5A5A);
        chk("b2b_c1_be", 32'(m.MemBe), 32'h1);
        step();
        drive(1'b1, 1'b1, 1'b0, LS_W, 32'h20, '0);
        #1 chk("b2b_c2_resp", 32'(RespValid), 32'h1);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        #1 chk("b2b_c3_req", 32'(m.MemReq), 32'h1);
        chk("b2b_c3_addr", m.MemAddr, 32'h20);
        step();
        #1 chk("b2b_c4_resp", 32'(RespValid), 32'h1);
        chk("b2b_c4_rd", ReadData, 32'hCAFE_F00D);
        m.MemReady = 1'b0;

        // async reset while waiting in REQ
        step();
        drive(1'b1, 1'b1, 1'b0, LS_W, 32'h40, '0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        #1 chk("rreq_req", 32'(m.MemReq), 32'h1);
        rst = 1'b1;
        #1 chk("rreq_req_rst", 32'(m.MemReq), 32'h0);
        chk("rreq_stall_rst", 32'(Stall), 32'h0);
        chk("rreq_resp_rst", 32'(RespValid), 32'h0);
        #1 rst = 1'b0;
        run_op(1'b1, 1'b0, LS_W, 32'h20, '0, 0, rd, nreq, lat, flt, be, wdv);
        chk("post_rst_rd", rd, 32'hCAFE_F00D);
        chk("post_rst_lat", 32'(lat), 32'd2);

        // random traffic, including ops during REQ and FAULT that must be ignored
        for (int i = 0; i < 800; i++) begin
            int k;
            logic [2:0] t;
            step();
            k = $urandom_range(0, 9);
            t = ($urandom_range(0, 9) < 7) ? legal_t[$urandom_range(0, 4)] : 3'($urandom);
            drive(($urandom_range(0, 2) != 0), (k < 5) || (k == 9), (k >= 4),
                  t, ($urandom & 32'hFF) | (($urandom & 1) << 28), $urandom);
            m.MemReady = ($urandom_range(0, 2) != 0);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        m.MemReady = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
